// File: rtl/awp_seq.sv
// Purpose: AWP operation sequencer; fetches operands, starts the AWP, writes r1..r3 back.
// Latency: float op, 0-wait memory: 1 + 3*2 + 1 + W + 3 + 1 cycles start..done (W = WAIT cycles).
// Backpressure: rd_req/rd_addr held until rd_ack; start ignored while busy, no queueing.
//
// Ports:
//   clk_sys, clr_          clock (rising edge), asynchronous active-low reset
//   start, op, nrf, ea     instruction request; op/nrf/ea latched when start is accepted in IDLE
//   abort                  synchronous cancel, returns to IDLE from any state without done
//   rd_req/rd_addr         memory read request, address = ea + word index (mod 2^16)
//   rd_ack/rd_data         memory acknowledge with data in the same cycle
//   opnd_we/idx/data       argument latch write, one cycle after each rd_ack
//   awp_go, awp_ekc        AWP start pulse and completion
//   reg_we, reg_sel        register-file write, reg_sel 1..N_out ascending
//   busy, done, err_to     status: busy while not IDLE, done pulse, sticky watchdog timeout
//
// Build option: define AWP_SEQ_WDOG_EN to enable the WAIT watchdog (WDOG_CYC cycles);
// without it WAIT waits on awp_ekc forever and err_to is tied low.
module awp_seq #(
  parameter int WDOG_CYC = 255
) (
  input  logic        clk_sys,
  input  logic        clr_,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        nrf,
  input  logic        abort,
  input  logic [15:0] ea,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic        opnd_we,
  output logic [1:0]  opnd_idx,
  output logic [15:0] opnd_data,
  output logic        awp_go,
  input  logic        awp_ekc,
  output logic        reg_we,
  output logic [1:0]  reg_sel,
  output logic        busy,
  output logic        done,
  output logic        err_to
);

  // S_LATCH is the second half of each operand fetch: the registered word is written
  // into the argument latch while rd_req is low for that cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_GO, S_WAIT, S_WB, S_DONE
  } state_t;

  state_t      state, state_n;
  logic        float_q;
  logic        nrf_q;
  logic [15:0] ea_q;
  logic [15:0] data_q;
  logic [1:0]  k;
  logic [1:0]  n_in;
  logic [1:0]  n_out;
  logic        accept;
  logic        fetch_last;
  logic        wb_last;
  logic        timeout;

  // Only the float/fixed distinction (op[2]) changes the word counts.
  logic unused_op;
  assign unused_op = ^op[1:0];

  assign n_in       = nrf_q ? 2'd0 : (float_q ? 2'd3 : 2'd2);
  assign n_out      = (nrf_q || float_q) ? 2'd3 : 2'd2;
  assign accept     = (state == S_IDLE) && start && !abort;
  assign fetch_last = (k == n_in - 2'd1);
  assign wb_last    = (k == n_out - 2'd1);

  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      state   <= S_IDLE;
      float_q <= 1'b0;
      nrf_q   <= 1'b0;
      ea_q    <= 16'd0;
      data_q  <= 16'd0;
      k       <= 2'd0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (accept) begin
            ea_q    <= ea;
            float_q <= op[2];
            nrf_q   <= nrf;
            k       <= 2'd0;
          end
        end
        S_FETCH: if (rd_ack) data_q <= rd_data;
        S_LATCH: k <= k + 2'd1;
        S_GO:    k <= 2'd0;   // k is reused as the write-back index
        S_WB:    k <= k + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = nrf ? S_GO : S_FETCH;
      S_FETCH: if (rd_ack) state_n = S_LATCH;
      S_LATCH: state_n = fetch_last ? S_GO : S_FETCH;
      S_GO:    state_n = S_WAIT;
      S_WAIT: begin
        // A completion arriving in the last watchdog cycle still wins.
        if (awp_ekc)      state_n = S_WB;
        else if (timeout) state_n = S_DONE;
      end
      S_WB:    if (wb_last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

`ifdef AWP_SEQ_WDOG_EN
  logic [7:0] wcnt;
  logic       err_q;

  assign timeout = (wcnt == 8'(WDOG_CYC - 1));
  assign err_to  = err_q;

  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      wcnt  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (accept) err_q <= 1'b0;
      if (state == S_GO)        wcnt <= 8'd0;
      else if (state == S_WAIT) wcnt <= wcnt + 8'd1;
      if (state == S_WAIT && !awp_ekc && !abort && timeout) err_q <= 1'b1;
    end
  end
`else
  localparam int wdog_unused = WDOG_CYC;
  assign timeout = 1'b0;
  assign err_to  = 1'b0;
`endif

  // Data-carrying outputs are forced to zero whenever their strobe is low.
  assign rd_req    = (state == S_FETCH);
  assign rd_addr   = rd_req ? (ea_q + {14'd0, k}) : 16'd0;
  assign opnd_we   = (state == S_LATCH);
  assign opnd_idx  = opnd_we ? k : 2'd0;
  assign opnd_data = opnd_we ? data_q : 16'd0;
  assign awp_go    = (state == S_GO);
  assign reg_we    = (state == S_WB);
  assign reg_sel   = reg_we ? (k + 2'd1) : 2'd0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_awp_seq.sv
// Purpose: self-checking bench for awp_seq (table-driven ops plus abort/reset/watchdog sequences).
// Latency: expected start..done latencies are constants in the vector table.
// Backpressure: memory model acks after a per-vector delay; AWP model raises ekc after a delay.
module tb_awp_seq;

  logic        clk_sys = 1'b0;
  logic        clr_    = 1'b0;
  logic        start   = 1'b0;
  logic [2:0]  op      = 3'd0;
  logic        nrf     = 1'b0;
  logic        abort   = 1'b0;
  logic [15:0] ea      = 16'd0;
  logic        rd_ack  = 1'b0;
  logic [15:0] rd_data = 16'd0;
  logic        awp_ekc = 1'b0;
  logic        rd_req, opnd_we, awp_go, reg_we, busy, done, err_to;
  logic [15:0] rd_addr, opnd_data;
  logic [1:0]  opnd_idx, reg_sel;

  always #5 clk_sys = ~clk_sys;

  awp_seq #(.WDOG_CYC(8)) dut (
    .clk_sys(clk_sys), .clr_(clr_), .start(start), .op(op), .nrf(nrf), .abort(abort),
    .ea(ea), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .opnd_we(opnd_we), .opnd_idx(opnd_idx), .opnd_data(opnd_data), .awp_go(awp_go),
    .awp_ekc(awp_ekc), .reg_we(reg_we), .reg_sel(reg_sel), .busy(busy), .done(done),
    .err_to(err_to)
  );

  typedef struct {
    logic        nrf;
    logic [2:0]  op;
    logic [15:0] ea;
    int          mem_dly;
    int          ekc_dly;
    bit          stray;
    bit          dup;
    int          exp_lat;
    int          exp_go;
    int          exp_nop;
    int          exp_nreg;
  } vec_t;

  vec_t vecs[6];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] q_addr[$];
  logic [17:0] q_opnd[$];
  logic [1:0]  q_reg[$];

  int mem_dly = 0;
  int ekc_dly = 0;
  bit stray   = 1'b0;
  int go_cnt = 0, done_cnt = 0, nop = 0, nreg = 0, go_cyc = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return (a ^ 16'h5AC3) + 16'd7;
  endfunction

  function automatic logic [63:0] outs();
    return {21'd0, rd_req, rd_addr, opnd_we, opnd_idx, opnd_data, awp_go, reg_we, reg_sel,
            busy, done, err_to};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic n, input logic [2:0] o, input logic [15:0] e, input bit wb);
    int ni;
    int no;
    ni = n ? 0 : (o[2] ? 3 : 2);
    no = (n || o[2]) ? 3 : 2;
    for (int j = 0; j < ni; j++) begin
      q_addr.push_back(e + 16'(j));
      q_opnd.push_back({2'(j), memfn(e + 16'(j))});
    end
    if (wb) for (int j = 0; j < no; j++) q_reg.push_back(2'(j + 1));
  endtask

  task automatic flush();
    q_addr.delete();
    q_opnd.delete();
    q_reg.delete();
  endtask

  task automatic clear_counts();
    go_cnt = 0; done_cnt = 0; nop = 0; nreg = 0; go_cyc = 0;
  endtask

  // Memory model: acks mem_dly cycles after rd_req is first seen; checks address order/stability.
  int          wc = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = 16'd0;
  always @(negedge clk_sys) begin
    if (!clr_) begin
      rd_ack = 1'b0; wc = 0; prev_req = 1'b0;
    end else begin
      if (rd_req) begin
        if (prev_req) chk("rd_addr_stable", rd_addr, prev_addr);
        if (wc >= mem_dly) begin
          if (q_addr.size() == 0) chk("rd_unexpected", 1, 0);
          else chk("rd_addr", rd_addr, q_addr.pop_front());
          rd_ack = 1'b1; rd_data = memfn(rd_addr); wc = 0;
        end else begin
          rd_ack = 1'b0; wc++;
        end
      end else begin
        rd_ack = stray; rd_data = 16'hBAD0; wc = 0;
      end
      prev_req = rd_req;
      prev_addr = rd_addr;
    end
  end

  // AWP model: single ekc pulse ekc_dly cycles after awp_go; ekc_dly=0 means never.
  int ec = 0;
  always @(negedge clk_sys) begin
    if (!clr_) begin
      awp_ekc = 1'b0; ec = 0;
    end else if (awp_go) begin
      awp_ekc = 1'b0; ec = ekc_dly;
    end else if (ec > 0) begin
      ec--; awp_ekc = (ec == 0);
    end else begin
      awp_ekc = 1'b0;
    end
  end

  // Output monitor: pops expected operand writes and register writes.
  always @(negedge clk_sys) begin
    if (clr_) begin
      if (awp_go) begin go_cnt++; go_cyc = cyc; end
      if (done) done_cnt++;
      if (opnd_we) begin
        nop++;
        if (q_opnd.size() == 0) chk("opnd_unexpected", 1, 0);
        else chk("opnd", {opnd_idx, opnd_data}, q_opnd.pop_front());
      end
      if (reg_we) begin
        nreg++;
        if (q_reg.size() == 0) chk("reg_unexpected", 1, 0);
        else chk("reg_sel", reg_sel, q_reg.pop_front());
      end
    end
  end

  task automatic run_vec(input int i);
    vec_t v;
    int   c0;
    int   c1;
    bit   got;
    v = vecs[i];
    mem_dly = v.mem_dly; ekc_dly = v.ekc_dly; stray = v.stray;
    clear_counts();
    push_exp(v.nrf, v.op, v.ea, 1'b1);
    @(negedge clk_sys);
    nrf = v.nrf; op = v.op; ea = v.ea; start = 1'b1; c0 = cyc;
    got = 1'b0; c1 = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk_sys);
      // Scramble the request inputs: the op must run from the latched copy.
      start = v.dup && (cyc == c0 + 3);
      ea = 16'hDEAD; op = ~v.op; nrf = 1'b0;
      if (done) begin got = 1'b1; c1 = cyc; end
    end
    start = 1'b0; stray = 1'b0;
    chk($sformatf("v%0d_done_seen", i), got, 1);
    chk($sformatf("v%0d_latency", i), c1 - c0 + 1, v.exp_lat);
    chk($sformatf("v%0d_go_offset", i), go_cyc - c0, v.exp_go);
    repeat (3) @(negedge clk_sys);
    chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
    chk($sformatf("v%0d_go_cnt", i), go_cnt, 1);
    chk($sformatf("v%0d_opnd_cnt", i), nop, v.exp_nop);
    chk($sformatf("v%0d_reg_cnt", i), nreg, v.exp_nreg);
    chk($sformatf("v%0d_sb_empty", i), q_addr.size() + q_opnd.size() + q_reg.size(), 0);
    chk($sformatf("v%0d_idle_outs", i), outs(), 0);
    flush();
  endtask

  initial begin
    int  c0;
    int  c1;
    bit  got;
    logic e;
    //          nrf   op    ea        mdly ekc stray dup  lat go nop nreg
    vecs[0] = '{1'b0, 3'd4, 16'h0100, 0,   4,  1'b0, 1'b0, 16,  7, 3, 3}; // AF
    vecs[1] = '{1'b0, 3'd3, 16'hFFFF, 0,   2,  1'b1, 1'b0, 11,  5, 2, 2}; // DW, wrap
    vecs[2] = '{1'b1, 3'd5, 16'h1234, 0,   1,  1'b0, 1'b0,  7,  1, 0, 3}; // nrf
    vecs[3] = '{1'b0, 3'd2, 16'h2000, 5,   3,  1'b0, 1'b1, 22, 15, 2, 2}; // MW, slow mem
    vecs[4] = '{1'b0, 3'd0, 16'h7FFE, 1,   1,  1'b0, 1'b0, 12,  7, 2, 2}; // AD
    vecs[5] = '{1'b0, 3'd7, 16'hFFFE, 2,   6,  1'b1, 1'b0, 24, 13, 3, 3}; // DF, wrap

    repeat (2) @(negedge clk_sys);
    chk("reset_outs", outs(), 0);
    clr_ = 1'b1;
    @(negedge clk_sys);
    chk("idle_outs", outs(), 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // abort while waiting for the AWP
    mem_dly = 0; ekc_dly = 0;
    clear_counts();
    push_exp(1'b0, 3'd4, 16'h0300, 1'b0);
    @(negedge clk_sys);
    start = 1'b1; nrf = 1'b0; op = 3'd4; ea = 16'h0300;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk_sys);
      start = 1'b0;
      if (awp_go) got = 1'b1;
    end
    chk("abort_go_seen", got, 1);
    repeat (3) @(negedge clk_sys);
    chk("abort_wait_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    chk("abort_outs", outs(), 0);
    repeat (3) @(negedge clk_sys);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_opnd_cnt", nop, 3);
    chk("abort_reg_cnt", nreg, 0);
    flush();

    // abort and start together in IDLE: abort wins
    @(negedge clk_sys);
    start = 1'b1; abort = 1'b1; nrf = 1'b1;
    @(negedge clk_sys);
    start = 1'b0; abort = 1'b0; nrf = 1'b0;
    chk("abort_start_outs", outs(), 0);
    @(negedge clk_sys);
    chk("abort_start_idle", outs(), 0);

    // asynchronous reset in the middle of an operand fetch
    mem_dly = 5;
    clear_counts();
    @(negedge clk_sys);
    start = 1'b1; nrf = 1'b0; op = 3'd2; ea = 16'h0400;
    @(negedge clk_sys);
    start = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("fetch_req", {rd_req, rd_addr}, {1'b1, 16'h0400});
    #2 clr_ = 1'b0;
    #1 chk("clr_outs", outs(), 0);
    @(negedge clk_sys);
    clr_ = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("clr_no_done", done_cnt, 0);
    chk("clr_idle_outs", outs(), 0);
    flush();

`ifdef AWP_SEQ_WDOG_EN
    // watchdog: ekc never arrives
    mem_dly = 0; ekc_dly = 0;
    clear_counts();
    push_exp(1'b0, 3'd4, 16'h0500, 1'b0);
    @(negedge clk_sys);
    start = 1'b1; nrf = 1'b0; op = 3'd4; ea = 16'h0500; c0 = cyc;
    got = 1'b0; c1 = 0; e = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk_sys);
      start = 1'b0;
      if (done) begin got = 1'b1; c1 = cyc; e = err_to; end
    end
    chk("wdog_done_seen", got, 1);
    chk("wdog_latency", c1 - c0 + 1, 17);
    chk("wdog_err_at_done", e, 1);
    repeat (3) @(negedge clk_sys);
    chk("wdog_done_cnt", done_cnt, 1);
    chk("wdog_reg_cnt", nreg, 0);
    chk("wdog_err_sticky", err_to, 1);
    flush();
    // next start clears err_to
    ekc_dly = 1;
    clear_counts();
    push_exp(1'b1, 3'd0, 16'h0000, 1'b1);
    @(negedge clk_sys);
    start = 1'b1; nrf = 1'b1;
    @(negedge clk_sys);
    start = 1'b0; nrf = 1'b0;
    chk("wdog_err_cleared", err_to, 0);
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk_sys);
      if (done) got = 1'b1;
    end
    chk("wdog_next_done", got, 1);
    repeat (2) @(negedge clk_sys);
    chk("wdog_next_reg_cnt", nreg, 3);
    flush();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
